// File: rtl/bd_pkg.sv
// bd_pkg: shared FSM type, control-bit indices and preamble constants for the BD modulator.
package bd_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} tx_state_t;
    localparam int CTRL_TXENABLE = 0;
    localparam int CTRL_INTMASK = 1;
    localparam int DATA_BITS = 16;
    localparam int PREAMBLE_BITS = 8;
    localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
endpackage

// File: rtl/bd_tone_gen.sv
// bd_tone_gen: maps bit value and in-bit sample index to a signed DAC sample.
// '1' is a flat +AMPLITUDE level; '0' is a square tone starting negative, so every bit ends positive.
module bd_tone_gen #(
    parameter int CNT_W = 5,
    parameter int HALF_PERIOD = 4,
    parameter logic signed [7:0] AMPLITUDE = 8'sd100
) (
    input  logic [CNT_W-1:0]  clk_cnt,
    input  logic              bit_val,
    output logic signed [7:0] sample
);
    logic odd_half;
    always_comb begin
        odd_half = |((clk_cnt / CNT_W'(HALF_PERIOD)) & CNT_W'(1));
        sample = (bit_val || odd_half) ? AMPLITUDE : -AMPLITUDE;
    end
endmodule

// File: rtl/bd_modulator.sv
// bd_modulator: zero-crossing baseband modulator serialising {DATA_BYTE_1, DATA_BYTE_0} MSB first to DAC samples.
// Define BD_TX_PREAMBLE_EN to prefix every frame with the 8-bit PREAMBLE_PATTERN.
module bd_modulator
    import bd_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int HALF_PERIOD = 4,
    parameter logic signed [7:0] AMPLITUDE = 8'sd100
) (
    input  logic              G_CLK_TX,
    input  logic              reset,
    input  logic [7:0]        BD_CONTROL_IN,
    input  logic [7:0]        DATA_BYTE_0,
    input  logic [7:0]        DATA_BYTE_1,
    input  logic              tx_start,
    input  logic              int_clear,
    output logic signed [7:0] DAC,
    output logic              tx_busy,
    output logic              int_flag,
    output logic              int_tx_host
);
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    tx_state_t state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [3:0] bit_idx, bit_idx_nxt;
    logic [15:0] shreg, shreg_nxt;
    logic int_flag_nxt, txen, accept, bit_end, frame_done, bit_val;
    logic signed [7:0] tone;
    logic unused_ctrl;

    assign unused_ctrl = ^BD_CONTROL_IN[7:2];
    assign txen = BD_CONTROL_IN[CTRL_TXENABLE];
    assign accept = state == IDLE && tx_start && txen;
    assign bit_end = state != IDLE && clk_cnt == CNT_W'(SAMPLES_PER_BIT - 1);
    // A frame that loses TXENABLE on its final edge counts as aborted, not completed
    assign frame_done = state == DATA && txen && bit_end && bit_idx == 4'(DATA_BITS - 1);
`ifdef BD_TX_PREAMBLE_EN
    assign bit_val = state == PREAMBLE ? PREAMBLE_PATTERN[~bit_idx[2:0]] : shreg[15];
`else
    assign bit_val = shreg[15];
`endif

    always_comb begin
        state_nxt = state;
        clk_cnt_nxt = clk_cnt + CNT_W'(1);
        bit_idx_nxt = bit_end ? bit_idx + 4'd1 : bit_idx;
        shreg_nxt = (bit_end && state == DATA) ? shreg << 1 : shreg;
        int_flag_nxt = frame_done | (int_flag & ~int_clear);
        if (state == IDLE) begin
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
            if (accept) begin
`ifdef BD_TX_PREAMBLE_EN
                state_nxt = PREAMBLE;
`else
                state_nxt = DATA;
`endif
                shreg_nxt = {DATA_BYTE_1, DATA_BYTE_0};
            end
        end else if (!txen || frame_done) begin
            state_nxt = IDLE;
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
        end
`ifdef BD_TX_PREAMBLE_EN
        else if (state == PREAMBLE && bit_end && bit_idx == 4'(PREAMBLE_BITS - 1)) begin
            state_nxt = DATA;
            bit_idx_nxt = '0;
        end
`endif
    end

    always_ff @(posedge G_CLK_TX or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            int_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg <= shreg_nxt;
            int_flag <= int_flag_nxt;
        end
    end

    bd_tone_gen #(
        .CNT_W(CNT_W),
        .HALF_PERIOD(HALF_PERIOD),
        .AMPLITUDE(AMPLITUDE)
    ) u_tone (
        .clk_cnt(clk_cnt),
        .bit_val(bit_val),
        .sample(tone)
    );

    assign DAC = state == IDLE ? 8'sd0 : tone;
    assign tx_busy = state != IDLE;
    assign int_tx_host = int_flag & BD_CONTROL_IN[CTRL_INTMASK];
endmodule

// File: tb/tb_bd_modulator.sv
// tb_bd_modulator: table-driven frames checked against a sample scoreboard and a zero-crossing receiver model.
module tb_bd_modulator;
    localparam int SPB = 32;
    localparam int HP = 4;
    localparam int AMP = 100;
`ifdef BD_TX_PREAMBLE_EN
    localparam int NB = 24;
`else
    localparam int NB = 16;
`endif
    localparam int FRAME = NB * SPB;

    typedef struct {
        logic [7:0] b1;
        logic [7:0] b0;
        logic mask;
        logic clr_hold;
        logic exp_flag;
        logic exp_host;
    } vec_t;

    logic G_CLK_TX = 1'b0;
    logic reset = 1'b1;
    logic tx_start = 1'b0;
    logic int_clear = 1'b0;
    logic [7:0] BD_CONTROL_IN = 8'h00;
    logic [7:0] DATA_BYTE_0 = 8'h00;
    logic [7:0] DATA_BYTE_1 = 8'h00;
    logic [7:0] DAC;
    logic tx_busy, int_flag, int_tx_host;
    int checks = 0;
    int errors = 0;
    int sb[$];
    vec_t vecs[5];
    logic [23:0] rx;

    bd_modulator #(
        .SAMPLES_PER_BIT(SPB),
        .HALF_PERIOD(HP),
        .AMPLITUDE(8'sd100)
    ) dut (
        .G_CLK_TX(G_CLK_TX),
        .reset(reset),
        .BD_CONTROL_IN(BD_CONTROL_IN),
        .DATA_BYTE_0(DATA_BYTE_0),
        .DATA_BYTE_1(DATA_BYTE_1),
        .tx_start(tx_start),
        .int_clear(int_clear),
        .DAC(DAC),
        .tx_busy(tx_busy),
        .int_flag(int_flag),
        .int_tx_host(int_tx_host)
    );

    always #5 G_CLK_TX = ~G_CLK_TX;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge G_CLK_TX);
        #1;
    endtask

    function automatic int exp_sample(input logic [23:0] fr, input int k);
        int b, c;
        b = k / SPB;
        c = k % SPB;
        if (fr[NB-1-b]) return AMP;
        return ((c / HP) % 2 == 0) ? -AMP : AMP;
    endfunction

    // Starts a frame, checks stop_at samples, and decodes them like the BD receiver (sign changes per bit)
    task automatic run_frame(input logic [7:0] b1, input logic [7:0] b0, input int stop_at, output logic [23:0] rxw);
        logic [23:0] fr;
        logic prev_neg, neg;
        int cnt;
`ifdef BD_TX_PREAMBLE_EN
        fr = {8'hAA, b1, b0};
`else
        fr = {8'h00, b1, b0};
`endif
        for (int k = 0; k < FRAME; k++) sb.push_back(exp_sample(fr, k));
        DATA_BYTE_1 = b1;
        DATA_BYTE_0 = b0;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        rxw = '0;
        prev_neg = 1'b0;
        cnt = 0;
        for (int k = 0; k < stop_at; k++) begin
            chk("dac_sample", int'($signed(DAC)), sb.pop_front());
            chk("tx_busy_frame", int'(tx_busy), 1);
            neg = DAC[7];
            if (neg != prev_neg) cnt++;
            prev_neg = neg;
            if (k % SPB == SPB - 1) begin
                rxw = {rxw[22:0], cnt < 2};
                cnt = 0;
            end
            // A start request while busy, with new bytes, must not disturb the frame in flight
            if (k == 40) begin
                DATA_BYTE_1 = ~b1;
                DATA_BYTE_0 = ~b0;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            tick;
        end
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) tick;
        chk("reset_dac", int'(DAC), 0);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_flag", int'(int_flag), 0);
        chk("reset_host", int'(int_tx_host), 0);
        reset = 1'b0;
        BD_CONTROL_IN = 8'h03;
        tick;
        chk("idle_dac", int'(DAC), 0);

        // Reset mid-frame with int_flag already set
        run_frame(8'hFF, 8'h00, FRAME, rx);
        chk("pre_reset_flag", int'(int_flag), 1);
        run_frame(8'h5A, 8'hC3, 60, rx);
        #2 reset = 1'b1;
        #1;
        chk("midreset_dac", int'(DAC), 0);
        chk("midreset_busy", int'(tx_busy), 0);
        chk("midreset_flag", int'(int_flag), 0);
        tick;
        reset = 1'b0;
        tick;
        chk("post_reset_dac", int'(DAC), 0);

        foreach (vecs[i]) begin
            BD_CONTROL_IN = {6'b0, vecs[i].mask, 1'b1};
            int_clear = vecs[i].clr_hold;
            run_frame(vecs[i].b1, vecs[i].b0, FRAME, rx);
            chk("rx_data", int'(rx[15:0]), int'({vecs[i].b1, vecs[i].b0}));
`ifdef BD_TX_PREAMBLE_EN
            chk("rx_preamble", int'(rx[23:16]), 8'hAA);
`endif
            chk("end_dac", int'(DAC), 0);
            chk("end_busy", int'(tx_busy), 0);
            chk("end_flag", int'(int_flag), int'(vecs[i].exp_flag));
            chk("end_host", int'(int_tx_host), int'(vecs[i].exp_host));
            int_clear = 1'b1;
            tick;
            int_clear = 1'b0;
            chk("clear_flag", int'(int_flag), 0);
            chk("clear_host", int'(int_tx_host), 0);
        end

        // TXENABLE drops 100 cycles into a frame
        BD_CONTROL_IN = 8'h03;
        run_frame(8'h0F, 8'hF0, 100, rx);
        BD_CONTROL_IN = 8'h02;
        tick;
        chk("abort_dac", int'(DAC), 0);
        chk("abort_busy", int'(tx_busy), 0);
        chk("abort_flag", int'(int_flag), 0);
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("disabled_dac", int'(DAC), 0);
            chk("disabled_busy", int'(tx_busy), 0);
            tick;
        end
        chk("disabled_flag", int'(int_flag), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
